// File: rtl/ufm_read_sequencer_if.sv
// Avalon-MM CSR/data master signals of the flash read sequencer plus its
// valid/ready output stream.
interface ufm_read_sequencer_if #(
  parameter int unsigned ADDR_W = 17
);
  logic              avmm_csr_addr;
  logic              avmm_csr_read;
  logic              avmm_csr_write;
  logic [31:0]       avmm_csr_writedata;
  logic [31:0]       avmm_csr_readdata;

  logic [ADDR_W-1:0] avmm_data_addr;
  logic              avmm_data_read;
  logic [1:0]        avmm_data_burstcount;
  logic              avmm_data_write;
  logic [31:0]       avmm_data_writedata;
  logic              avmm_data_waitrequest;
  logic [31:0]       avmm_data_readdata;
  logic              avmm_data_readdatavalid;

  logic              out_valid;
  logic [31:0]       out_data;
  logic              out_ready;

  modport master (
    output avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    input  avmm_csr_readdata,
    output avmm_data_addr, avmm_data_read, avmm_data_burstcount, avmm_data_write,
    output avmm_data_writedata,
    input  avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  avmm_csr_addr, avmm_csr_read, avmm_csr_write, avmm_csr_writedata,
    output avmm_csr_readdata,
    input  avmm_data_addr, avmm_data_read, avmm_data_burstcount, avmm_data_write,
    input  avmm_data_writedata,
    output avmm_data_waitrequest, avmm_data_readdata, avmm_data_readdatavalid,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/ufm_read_sequencer.sv
// Polls the user-flash CSR until idle, then issues burst reads over a word range
// and buffers the returned words in a small FIFO drained by a valid/ready stream.
module ufm_read_sequencer #(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned POLL_LIMIT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W:0]      word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  ufm_read_sequencer_if.master bus
);
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PollW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  typedef enum logic [2:0] {StIdle, StPoll, StCheck, StReq, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [PollW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [1:0]        beats_q, beats_d;
  logic              error_q, error_d;

  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [1:0]        blen;
  logic [CntW-1:0]   free;
  logic              csr_read, data_read, push, pop;
  logic              unused_csr;

  assign unused_csr = ^bus.avmm_csr_readdata[31:2];

  // remaining_q is frozen between request and last beat, so blen stays valid through WAIT.
  always_comb begin
    blen = (remaining_q >= (ADDR_W+1)'(BURST_LEN)) ? 2'(BURST_LEN) : remaining_q[1:0];
    free = CntW'(FIFO_DEPTH) - count_q;
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    poll_cnt_d  = poll_cnt_q;
    beats_d     = beats_q;
    error_d     = error_q;
    csr_read    = 1'b0;
    data_read   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d      = start_addr;
          remaining_d = word_count;
          poll_cnt_d  = '0;
          error_d     = 1'b0;
          state_d     = (word_count == '0) ? StDone : StPoll;
        end
      end
      StPoll: begin
        csr_read = 1'b1;
        state_d  = StCheck;
      end
      StCheck: begin
        if (bus.avmm_csr_readdata[1:0] == 2'b00) begin
          state_d = StReq;
        end else if (poll_cnt_q == PollW'(POLL_LIMIT - 1)) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          poll_cnt_d = poll_cnt_q + PollW'(1);
          state_d    = StPoll;
        end
      end
      StReq: begin
        // Space is reserved up front so returning beats never need back-pressure.
        if (free >= CntW'(blen)) begin
          data_read = 1'b1;
          if (!bus.avmm_data_waitrequest) begin
            beats_d = blen;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (bus.avmm_data_readdatavalid) begin
          beats_d = beats_q - 2'd1;
          if (beats_q == 2'd1) begin
            remaining_d = remaining_q - (ADDR_W+1)'(blen);
            addr_d      = addr_q + ADDR_W'(blen);
            state_d     = (remaining_q == (ADDR_W+1)'(blen)) ? StDone : StReq;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    push     = (state_q == StWait) && bus.avmm_data_readdatavalid;
    pop      = (count_q != '0) && bus.out_ready;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      poll_cnt_q  <= '0;
      beats_q     <= '0;
      error_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      poll_cnt_q  <= poll_cnt_d;
      beats_q     <= beats_d;
      error_q     <= error_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.avmm_data_readdata;
    end
  end

  always_comb begin
    busy                     = (state_q != StIdle);
    done                     = (state_q == StDone);
    error                    = error_q;
    bus.avmm_csr_addr        = 1'b0;
    bus.avmm_csr_read        = csr_read;
    bus.avmm_csr_write       = 1'b0;
    bus.avmm_csr_writedata   = '0;
    bus.avmm_data_addr       = addr_q;
    bus.avmm_data_read       = data_read;
    bus.avmm_data_burstcount = data_read ? blen : 2'b00;
    bus.avmm_data_write      = 1'b0;
    bus.avmm_data_writedata  = '0;
    bus.out_valid            = (count_q != '0);
    bus.out_data             = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  end
endmodule

// File: tb/tb_ufm_read_sequencer.sv
// Scoreboard bench for ufm_read_sequencer: a flash slave model returns addressed
// words, expected bursts and words are queued at start and checked as they appear.
module tb_ufm_read_sequencer;
  localparam int unsigned AW    = 17;
  localparam int unsigned AMASK = (1 << AW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, error;

  ufm_read_sequencer_if #(.ADDR_W(AW)) bus ();

  ufm_read_sequencer #(
    .ADDR_W(AW), .BURST_LEN(2), .FIFO_DEPTH(4), .POLL_LIMIT(255)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .bus        (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned exp_word_q[$];
  int unsigned exp_burst_q[$];  // {addr, len[1:0]}
  int unsigned beat_q[$];

  int unsigned busy_polls = 0, poll_base = 0, burst_base = 0, beat_base = 0;
  int unsigned polls_total = 0, bursts_total = 0, beats_total = 0;
  int unsigned stall_cycles = 0, gap_min = 0, gap_max = 2, ready_mode = 0;
  int unsigned exp_polls = 0, exp_bursts = 0;
  logic [1:0]  busy_val = 2'b10;
  logic        exp_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input int unsigned a);
    logic [31:0] v;
    v = a;
    return 32'h5A00_0000 ^ (v * 32'h0001_9E37) ^ {v[15:0], 16'h0};
  endfunction

  // Consumer ready, changed just after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    case (ready_mode)
      0:       bus.out_ready = 1'b1;
      2:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(1, 0));
    endcase
  end

  // Flash slave model: CSR status, data request stall/accept, beat return.
  logic [31:0]   st;
  bit            in_req = 0;
  int unsigned   req_addr, req_len, stall_left, gap_cnt, eb;
  always @(negedge clock) begin
    if (!reset_n) begin
      beat_q.delete();
      in_req = 0;
      gap_cnt = 0;
      bus.avmm_csr_readdata = '0;
      bus.avmm_data_waitrequest = 1'b0;
      bus.avmm_data_readdatavalid = 1'b0;
      bus.avmm_data_readdata = '0;
    end else begin
      bus.avmm_data_readdatavalid = 1'b0;
      bus.avmm_data_readdata = $urandom;
      if (gap_cnt > 0) begin
        gap_cnt--;
      end else if (beat_q.size() > 0) begin
        bus.avmm_data_readdatavalid = 1'b1;
        bus.avmm_data_readdata = mem_word(beat_q.pop_front());
        beats_total++;
        gap_cnt = $urandom_range(gap_max, gap_min);
      end
      if (bus.avmm_csr_read) begin
        polls_total++;
        st = $urandom;
        st[1:0] = ((polls_total - poll_base) <= busy_polls) ? busy_val : 2'b00;
        bus.avmm_csr_readdata = st;
      end
      if (bus.avmm_data_read) begin
        if (!in_req) begin
          in_req = 1;
          req_addr = bus.avmm_data_addr;
          req_len = bus.avmm_data_burstcount;
          stall_left = stall_cycles;
        end else begin
          check("req_addr_stable", bus.avmm_data_addr, req_addr);
          check("req_len_stable", bus.avmm_data_burstcount, req_len);
        end
        if (stall_left > 0) begin
          stall_left--;
          bus.avmm_data_waitrequest = 1'b1;
        end else begin
          bus.avmm_data_waitrequest = 1'b0;
          in_req = 0;
          bursts_total++;
          check("burst_expected", exp_burst_q.size() > 0, 1);
          if (exp_burst_q.size() > 0) begin
            eb = exp_burst_q.pop_front();
            check("burst_addr", req_addr, eb >> 2);
            check("burst_len", req_len, eb & 3);
          end
          for (int i = 0; i < int'(req_len); i++) beat_q.push_back((req_addr + i) & AMASK);
        end
      end else begin
        in_req = 0;
        bus.avmm_data_waitrequest = 1'($urandom_range(1, 0));
      end
    end
  end

  // Output monitor.
  always @(negedge clock) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      check("word_expected", exp_word_q.size() > 0, 1);
      if (exp_word_q.size() > 0) check("out_data", bus.out_data, exp_word_q.pop_front());
    end
  end

  task automatic issue(input int unsigned a, input int unsigned cnt, input int unsigned bp);
    int unsigned rem, cur, l;
    busy_polls = bp;
    busy_val   = 2'($urandom_range(3, 1));
    poll_base  = polls_total;
    burst_base = bursts_total;
    exp_err    = 1'b0;
    exp_polls  = 0;
    exp_bursts = 0;
    if (cnt != 0) begin
      if (bp >= 255) begin
        exp_err   = 1'b1;
        exp_polls = 255;
      end else begin
        exp_polls = bp + 1;
        rem = cnt;
        cur = a;
        while (rem > 0) begin
          l = (rem < 2) ? rem : 2;
          exp_burst_q.push_back((cur << 2) | l);
          exp_bursts++;
          cur = (cur + l) & AMASK;
          rem -= l;
        end
        for (int unsigned i = 0; i < cnt; i++) exp_word_q.push_back(mem_word((a + i) & AMASK));
      end
    end
    @(posedge clock);
    #1;
    start      = 1'b1;
    start_addr = AW'(a);
    word_count = (AW+1)'(cnt);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_op(input bit chk_latency);
    int  cyc;
    bit  seen;
    cyc  = 0;
    seen = 0;
    while (cyc < 3000 && !seen) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check("busy_after_start", busy, 1);
        check("error_cleared_on_start", error, 0);
      end
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (chk_latency) check("zero_count_done_latency", cyc, 1);
    check("error_at_done", error, exp_err);
    check("poll_count", polls_total - poll_base, exp_polls);
    check("burst_count", bursts_total - burst_base, exp_bursts);
    check("bursts_left", exp_burst_q.size(), 0);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    ready_mode = 0;
    for (int k = 0; k < 100 && exp_word_q.size() > 0; k++) begin
      @(negedge clock);
      #1;
    end
    check("words_left", exp_word_q.size(), 0);
    exp_word_q.delete();
    exp_burst_q.delete();
    @(negedge clock);
    check("fifo_empty_after_drain", bus.out_valid, 0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_csr_read", bus.avmm_csr_read, 0);
    check("rst_data_read", bus.avmm_data_read, 0);
    check("rst_data_addr", bus.avmm_data_addr, 0);
    check("rst_burstcount", bus.avmm_data_burstcount, 0);
    check("rst_writes", {bus.avmm_csr_write, bus.avmm_data_write, bus.avmm_csr_addr}, 0);
    check("rst_writedata", {bus.avmm_csr_writedata, bus.avmm_data_writedata}, 0);
    #1 reset_n = 1'b1;

    // Basic 5-word read; a start pulse during the operation must be ignored.
    issue('h10, 5, 0);
    @(posedge clock);
    #1;
    start = 1'b1; start_addr = 'h777; word_count = 3;
    @(posedge clock);
    #1;
    start = 1'b0;
    finish_op(0);

    // Busy status three times, then idle.
    issue('h20, 3, 3);
    finish_op(0);

    // Status never idle: poll timeout.
    issue('h30, 4, 300);
    finish_op(0);
    check("error_sticky", error, 1);

    // Stalled requests with a stopped consumer: only two bursts fit the FIFO.
    stall_cycles = 3;
    ready_mode   = 2;
    issue('h100, 8, 0);
    repeat (60) @(negedge clock);
    check("withheld_bursts", bursts_total - burst_base, 2);
    check("withheld_read_low", bus.avmm_data_read, 0);
    check("withheld_out_valid", bus.out_valid, 1);
    ready_mode = 1;
    finish_op(0);
    stall_cycles = 0;

    // Address wrap and zero-length request.
    issue('h1FFFF, 2, 0);
    finish_op(0);
    issue('h1FFFF, 4, 0);
    finish_op(0);
    issue('h5, 0, 0);
    finish_op(1);

    // Reset during WAIT with one beat still outstanding.
    gap_min = 3; gap_max = 3; ready_mode = 2;
    beat_base = beats_total;
    issue('h40, 8, 0);
    for (int k = 0; k < 300 && (beats_total - beat_base) < 3; k++) @(negedge clock);
    check("reset_test_reached_beat3", beats_total - beat_base, 3);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data_read", bus.avmm_data_read, 0);
    check("midrst_done_error", {done, error}, 0);
    repeat (2) @(negedge clock);
    exp_word_q.delete();
    exp_burst_q.delete();
    @(negedge clock);
    #1 reset_n = 1'b1;
    gap_min = 0; gap_max = 2; ready_mode = 0;
    issue('h1234, 5, 1);
    finish_op(0);

    // Randomized operations.
    for (int n = 0; n < 12; n++) begin
      int unsigned a;
      a = ($urandom_range(3, 0) == 0) ? AMASK - $urandom_range(4, 0) : $urandom_range(AMASK, 0);
      stall_cycles = $urandom_range(3, 0);
      gap_max      = $urandom_range(2, 0);
      ready_mode   = $urandom_range(1, 0);
      issue(a, $urandom_range(12, 0), $urandom_range(3, 0));
      finish_op(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
